tile_scan_mapper: RTL and testbench
===================================

// Module: tile_scan_mapper
// PURPOSE
// - Parametrised, registered tile-grid locator for the VGA pixel pipeline; sits between the VGA controller (DrawX/DrawY) and tile/sprite ROM lookup + colour mapper.
// - Per pixel: cell origin, cell row/col, in-cell offset, linear tile-map address, all registered.
// - Also owns the player cell position, moved by keycode once per frame with auto-repeat; flag marks pixels inside the player cell.
// PARAMETERS
// - TILE_W_LOG2  3    log2 tile width in pixels (8)
// - TILE_H_LOG2  4    log2 tile height in pixels (16)
// - H_ACTIVE     640  visible pixels per line
// - V_ACTIVE     480  visible lines per frame
// - ADDR_W       12   tile-map address width; must hold COLS*ROWS-1
// - MOVE_DIV     8    frames between auto-repeat steps while a key is held (>=1)
// - PLAYER_COL0  0    reset column of player cell
// - PLAYER_ROW0  0    reset row of player cell
// - Derived (localparam): COLS = H_ACTIVE>>TILE_W_LOG2, ROWS = V_ACTIVE>>TILE_H_LOG2
// PORTS
// - Clk           in   1       pixel clock; single clock domain
// - Reset         in   1       asynchronous, active-high reset
// - DrawX         in   10      current pixel column from VGA controller
// - DrawY         in   10      current pixel line from VGA controller
// - keycode       in   8       USB HID keycode; 0x1A up, 0x16 down, 0x04 left, 0x07 right, other = none
// - Sprite_X_Pos  out  10      cell origin X (DrawX, low TILE_W_LOG2 bits zeroed)
// - Sprite_Y_Pos  out  10      cell origin Y (DrawY, low TILE_H_LOG2 bits zeroed)
// - Off_X/Off_Y   out  TILE_W_LOG2 / TILE_H_LOG2   pixel offset inside cell
// - Map_Addr      out  ADDR_W  row*COLS+col; 0 when not active
// - Active        out  1       DrawX<H_ACTIVE && DrawY<V_ACTIVE
// - flag          out  1       Active && current cell == player cell
// - Player_Col/Player_Row out 7/6  player cell position
// BEHAVIOUR
// - Reset: all pixel outputs 0, Player=(PLAYER_COL0,PLAYER_ROW0), FSM IDLE, repeat counter 0.
// - Pixel path: fixed 1-cycle latency; outputs at edge N+1 reflect DrawX/DrawY sampled at edge N.
// - Map_Addr computed with shift-add only (no general multiplier); width-truncated to ADDR_W.
// - Inactive pixels: Active=0, flag=0, Map_Addr=0; origin/offset still follow DrawX/DrawY.
// - frame_tick: one-cycle internal pulse when DrawX==0 && DrawY==V_ACTIVE (start of vblank); moves commit only on frame_tick, so player never changes mid-visible-frame.
// - Move FSM (evaluated on frame_tick only):
//   IDLE: dir key -> step once, cnt=0, go HOLD; no key -> stay.
//   HOLD: key released -> IDLE; different dir key -> step immediately, cnt=0;
//         same key -> cnt++; when cnt==MOVE_DIV-1 step, cnt=0.
// - Edge rule (default): clamp; step past col 0/COLS-1 or row 0/ROWS-1 leaves position unchanged, FSM still advances.
// - Reset asserted mid-frame or mid-HOLD: immediate return to reset state; no partial step.
// - flag uses the player position registered before the pixel; a step on frame_tick is visible from the next pixel.
// CONFIGURATION
// - TILE_SCAN_WRAP_EN defined: step past an edge wraps (col COLS-1 -> 0, 0 -> COLS-1, rows likewise).
// - Undefined: clamp at edges as above. Pixel path identical in both builds.
// STRUCTURE
// - tile_pkg: HID keycode constants, move_state_t enum (IDLE, HOLD), dir_t enum (NONE, UP, DOWN, LEFT, RIGHT), key->dir decode function.
// - Sub-module tile_move_fsm: frame_tick + keycode in, Player_Col/Row out; parent holds pixel pipeline and tick generation.
// TESTING
// - Reset mid-frame, DrawX=100, DrawY=37 -> next edge: Sprite_X_Pos=96, Sprite_Y_Pos=32, Off_X=4, Off_Y=5, Map_Addr=2*80+12=172, Active=1.
// - DrawX=639,DrawY=479 -> Map_Addr=29*80+79=2399; DrawX=640 -> Active=0, Map_Addr=0, flag=0.
// - Hold 0x07 for 17 frames from (0,0), MOVE_DIV=8 -> steps on frames 1,9,17; Player_Col=3.
// - Player at col 0, press 0x04 -> clamp: col stays 0; with TILE_SCAN_WRAP_EN -> col 79.
// - Switch 0x07 -> 0x16 while in HOLD -> row+1 on the very next frame_tick, cnt restarts.
// - Player (3,2), scan DrawX=24..31, DrawY=32 -> flag=1 exactly those 8 pixels (1 cycle late); Reset during HOLD -> Player=(0,0), no step on next tick without key.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared definitions for the tile scan mapper: USB HID keycodes,
// move FSM states, step directions and the keycode-to-direction decode.
package tile_pkg;

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;

  typedef enum logic {IDLE, HOLD} move_state_t;

  typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT} dir_t;

  // Anything that is not one of the four arrow-style keys means "no move".
  function automatic dir_t key_to_dir(input logic [7:0] key);
    case (key)
      KEY_UP:    key_to_dir = UP;
      KEY_DOWN:  key_to_dir = DOWN;
      KEY_LEFT:  key_to_dir = LEFT;
      KEY_RIGHT: key_to_dir = RIGHT;
      default:   key_to_dir = NONE;
    endcase
  endfunction

endpackage

// File: rtl/tile_move_fsm.sv
// Player cell mover. Evaluated only on frame_tick: first press steps at once,
// a held key auto-repeats every MOVE_DIV frames, a new direction steps at once.
// Edge behaviour: clamp by default; define TILE_SCAN_WRAP_EN to wrap instead.
module tile_move_fsm
  import tile_pkg::*;
#(
  parameter int COLS        = 80,
  parameter int ROWS        = 30,
  parameter int MOVE_DIV    = 8,
  parameter int PLAYER_COL0 = 0,
  parameter int PLAYER_ROW0 = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic [6:0] player_col,
  output logic [5:0] player_row
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  move_state_t      state;
  dir_t             last_dir;
  logic [CNT_W-1:0] cnt;
  dir_t             dir;

  assign dir = key_to_dir(keycode);

  function automatic logic [6:0] next_col(input logic [6:0] c, input dir_t d);
    next_col = c;
`ifdef TILE_SCAN_WRAP_EN
    if (d == LEFT)  next_col = (c == 7'd0) ? 7'(COLS - 1) : c - 7'd1;
    if (d == RIGHT) next_col = (c == 7'(COLS - 1)) ? 7'd0 : c + 7'd1;
`else
    if (d == LEFT  && c != 7'd0)          next_col = c - 7'd1;
    if (d == RIGHT && c != 7'(COLS - 1))  next_col = c + 7'd1;
`endif
  endfunction

  function automatic logic [5:0] next_row(input logic [5:0] r, input dir_t d);
    next_row = r;
`ifdef TILE_SCAN_WRAP_EN
    if (d == UP)   next_row = (r == 6'd0) ? 6'(ROWS - 1) : r - 6'd1;
    if (d == DOWN) next_row = (r == 6'(ROWS - 1)) ? 6'd0 : r + 6'd1;
`else
    if (d == UP   && r != 6'd0)          next_row = r - 6'd1;
    if (d == DOWN && r != 6'(ROWS - 1))  next_row = r + 6'd1;
`endif
  endfunction

  // Move state machine with registered player position; idle between frame ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_dir   <= NONE;
      cnt        <= '0;
      player_col <= 7'(PLAYER_COL0);
      player_row <= 6'(PLAYER_ROW0);
    end else if (frame_tick) begin
      case (state)
        IDLE: begin
          if (dir != NONE) begin
            player_col <= next_col(player_col, dir);
            player_row <= next_row(player_row, dir);
            last_dir   <= dir;
            cnt        <= '0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (dir == NONE) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (dir != last_dir) begin
            player_col <= next_col(player_col, dir);
            player_row <= next_row(player_row, dir);
            last_dir   <= dir;
            cnt        <= '0;
          end else if (cnt == CNT_W'(MOVE_DIV - 1)) begin
            player_col <= next_col(player_col, dir);
            player_row <= next_row(player_row, dir);
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tile_scan_mapper.sv
// Registered tile-grid locator for the VGA pixel pipeline (1-cycle latency),
// plus frame-tick generation and the player cell mover.
// Optional build macro TILE_SCAN_WRAP_EN: player wraps at grid edges instead of clamping.
module tile_scan_mapper
  import tile_pkg::*;
#(
  parameter int TILE_W_LOG2 = 3,
  parameter int TILE_H_LOG2 = 4,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_W      = 12,
  parameter int MOVE_DIV    = 8,
  parameter int PLAYER_COL0 = 0,
  parameter int PLAYER_ROW0 = 0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic [7:0]             keycode,
  output logic [9:0]             Sprite_X_Pos,
  output logic [9:0]             Sprite_Y_Pos,
  output logic [TILE_W_LOG2-1:0] Off_X,
  output logic [TILE_H_LOG2-1:0] Off_Y,
  output logic [ADDR_W-1:0]      Map_Addr,
  output logic                   Active,
  output logic                   flag,
  output logic [6:0]             Player_Col,
  output logic [5:0]             Player_Row
);

  localparam int COLS = H_ACTIVE >> TILE_W_LOG2;
  localparam int ROWS = V_ACTIVE >> TILE_H_LOG2;

  // row*COLS + col built from shifted copies of row, one per set bit of COLS.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [9:0] r, input logic [9:0] c);
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(c);
    for (int i = 0; i < 16; i++) begin
      if (COLS[i]) acc = acc + (ADDR_W'(r) << i);
    end
    map_addr = acc;
  endfunction

  logic       frame_tick;
  logic [9:0] col_p0, row_p0;
  logic       vld_p0, hit_p0;

  logic [9:0]             sx_p1, sy_p1;
  logic [TILE_W_LOG2-1:0] ox_p1;
  logic [TILE_H_LOG2-1:0] oy_p1;
  logic [ADDR_W-1:0]      addr_p1;
  logic                   vld_p1, flag_p1;

  assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

  assign col_p0 = DrawX >> TILE_W_LOG2;
  assign row_p0 = DrawY >> TILE_H_LOG2;
  assign vld_p0 = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
  assign hit_p0 = (col_p0 == {3'b000, Player_Col}) && (row_p0 == {4'b0000, Player_Row});

  // ---- stage p0 -> p1: register cell geometry for the current pixel ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sx_p1   <= '0;
      sy_p1   <= '0;
      ox_p1   <= '0;
      oy_p1   <= '0;
      addr_p1 <= '0;
      vld_p1  <= 1'b0;
      flag_p1 <= 1'b0;
    end else begin
      sx_p1   <= {DrawX[9:TILE_W_LOG2], {TILE_W_LOG2{1'b0}}};
      sy_p1   <= {DrawY[9:TILE_H_LOG2], {TILE_H_LOG2{1'b0}}};
      ox_p1   <= DrawX[TILE_W_LOG2-1:0];
      oy_p1   <= DrawY[TILE_H_LOG2-1:0];
      addr_p1 <= vld_p0 ? map_addr(row_p0, col_p0) : '0;
      vld_p1  <= vld_p0;
      flag_p1 <= vld_p0 && hit_p0;
    end
  end

  assign Sprite_X_Pos = sx_p1;
  assign Sprite_Y_Pos = sy_p1;
  assign Off_X        = ox_p1;
  assign Off_Y        = oy_p1;
  assign Map_Addr     = addr_p1;
  assign Active       = vld_p1;
  assign flag         = flag_p1;

  tile_move_fsm #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .MOVE_DIV    (MOVE_DIV),
    .PLAYER_COL0 (PLAYER_COL0),
    .PLAYER_ROW0 (PLAYER_ROW0)
  ) u_move (
    .clk        (Clk),
    .rst        (Reset),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .player_col (Player_Col),
    .player_row (Player_Row)
  );

endmodule

// File: tb/tb_tile_scan_mapper.sv
// Bench for tile_scan_mapper: directed cases plus random pixels/keys,
// every cycle compared against an arithmetic reference model.
module tb_tile_scan_mapper;

  localparam int MOVE_DIV = 8;
  localparam int COLS     = 80;
  localparam int ROWS     = 30;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic [7:0]  keycode = '0;
  logic [9:0]  Sprite_X_Pos, Sprite_Y_Pos;
  logic [2:0]  Off_X;
  logic [3:0]  Off_Y;
  logic [11:0] Map_Addr;
  logic        Active, flag;
  logic [6:0]  Player_Col;
  logic [5:0]  Player_Row;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: player cell, held direction, frames held so far
  int m_col, m_row, m_dir, m_k;

  tile_scan_mapper #(
    .TILE_W_LOG2(3), .TILE_H_LOG2(4), .H_ACTIVE(640), .V_ACTIVE(480),
    .ADDR_W(12), .MOVE_DIV(MOVE_DIV), .PLAYER_COL0(0), .PLAYER_ROW0(0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .keycode(keycode),
    .Sprite_X_Pos(Sprite_X_Pos), .Sprite_Y_Pos(Sprite_Y_Pos),
    .Off_X(Off_X), .Off_Y(Off_Y), .Map_Addr(Map_Addr),
    .Active(Active), .flag(flag),
    .Player_Col(Player_Col), .Player_Row(Player_Row)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dir_of(input int key);
    case (key)
      8'h1A:   return 1;  // up
      8'h16:   return 2;  // down
      8'h04:   return 3;  // left
      8'h07:   return 4;  // right
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input int d);
`ifdef TILE_SCAN_WRAP_EN
    if (d == 1) m_row = (m_row + ROWS - 1) % ROWS;
    if (d == 2) m_row = (m_row + 1) % ROWS;
    if (d == 3) m_col = (m_col + COLS - 1) % COLS;
    if (d == 4) m_col = (m_col + 1) % COLS;
`else
    if (d == 1 && m_row > 0)        m_row = m_row - 1;
    if (d == 2 && m_row < ROWS - 1) m_row = m_row + 1;
    if (d == 3 && m_col > 0)        m_col = m_col - 1;
    if (d == 4 && m_col < COLS - 1) m_col = m_col + 1;
`endif
  endtask

  // Held key: steps on the 1st, (1+MOVE_DIV)th, (1+2*MOVE_DIV)th ... frame it is held.
  task automatic model_tick(input int key);
    int d;
    d = dir_of(key);
    if (d == 0) begin
      m_dir = 0;
    end else if (d != m_dir) begin
      m_dir = d;
      m_k   = 1;
      model_step(d);
    end else begin
      m_k++;
      if ((m_k - 1) % MOVE_DIV == 0) model_step(d);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_row = 0; m_dir = 0; m_k = 0;
  endtask

  // Drive one pixel, clock it, then compare every output against the model.
  task automatic cyc(input int x, input int y, input int key);
    int act, e_addr, e_flag;
    DrawX = 10'(x); DrawY = 10'(y); keycode = 8'(key);
    @(posedge Clk);
    act    = (x < 640 && y < 480) ? 1 : 0;
    e_addr = act ? (((y / 16) * COLS + x / 8) % 4096) : 0;
    e_flag = (act && (x / 8) == m_col && (y / 16) == m_row) ? 1 : 0;
    if (x == 0 && y == 480) model_tick(key);
    #1;
    check("sprite_x", Sprite_X_Pos, (x / 8) * 8);
    check("sprite_y", Sprite_Y_Pos, (y / 16) * 16);
    check("off_x", Off_X, x % 8);
    check("off_y", Off_Y, y % 16);
    check("map_addr", Map_Addr, e_addr);
    check("active", Active, act);
    check("flag", flag, e_flag);
    check("player_col", Player_Col, m_col);
    check("player_row", Player_Row, m_row);
  endtask

  task automatic tick(input int key);
    cyc(0, 480, key);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check("rst_sprite_x", Sprite_X_Pos, 0);
    check("rst_sprite_y", Sprite_Y_Pos, 0);
    check("rst_off", {Off_X, Off_Y}, 0);
    check("rst_addr", Map_Addr, 0);
    check("rst_active", Active, 0);
    check("rst_flag", flag, 0);
    check("rst_player_col", Player_Col, 0);
    check("rst_player_row", Player_Row, 0);
    @(posedge Clk);
    #3 Reset = 1'b0;
  endtask

  initial begin
    int fl;
    model_reset();
    DrawX = 10'd300; DrawY = 10'd200;
    repeat (2) @(posedge Clk);
    #1;
    do_reset();

    // mid-frame pixel geometry
    cyc(100, 37, 0);
    check("d_sx", Sprite_X_Pos, 96);
    check("d_sy", Sprite_Y_Pos, 32);
    check("d_ox", Off_X, 4);
    check("d_oy", Off_Y, 5);
    check("d_addr", Map_Addr, 172);
    check("d_active", Active, 1);

    // last visible pixel, then just outside the visible area
    cyc(639, 479, 0);
    check("d_addr_last", Map_Addr, 2399);
    cyc(640, 479, 0);
    check("d_inactive", Active, 0);
    check("d_inactive_addr", Map_Addr, 0);
    check("d_inactive_flag", flag, 0);
    cyc(5, 480, 0);
    check("d_vblank_active", Active, 0);

    // hold right for 17 frames with visible pixels in between
    for (int f = 0; f < 17; f++) begin
      tick(8'h07);
      cyc($urandom_range(0, 639), $urandom_range(0, 479), 8'h07);
    end
    check("d_hold17_col", Player_Col, 3);
    tick(0);

    // left at column 0
    do_reset();
    tick(8'h04);
`ifdef TILE_SCAN_WRAP_EN
    check("d_edge_col", Player_Col, 79);
`else
    check("d_edge_col", Player_Col, 0);
`endif
    tick(0);

    // direction switch while holding
    do_reset();
    tick(8'h07);
    tick(8'h07);
    tick(8'h16);
    check("d_switch_row", Player_Row, 1);
    check("d_switch_col", Player_Col, 1);
    for (int f = 0; f < 9; f++) tick(8'h16);
    check("d_switch_repeat_row", Player_Row, 2);
    tick(0);

    // walk to (3,2) and scan the row containing that cell
    do_reset();
    for (int i = 0; i < 3; i++) begin tick(8'h07); tick(0); end
    for (int i = 0; i < 2; i++) begin tick(8'h16); tick(0); end
    check("d_walk_col", Player_Col, 3);
    check("d_walk_row", Player_Row, 2);
    fl = 0;
    for (int x = 20; x <= 36; x++) begin
      cyc(x, 32, 0);
      fl += int'(flag);
    end
    check("d_flag_count", fl, 8);

    // reset while holding, then a keyless tick
    do_reset();
    tick(8'h07);
    tick(8'h07);
    do_reset();
    tick(0);
    check("d_rst_hold_col", Player_Col, 0);
    check("d_rst_hold_row", Player_Row, 0);

    // random pixels, keys and frame ticks
    for (int n = 0; n < 600; n++) begin
      int k, r;
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 5))
        0: k = 8'h1A;
        1: k = 8'h16;
        2: k = 8'h04;
        3: k = 8'h07;
        4: k = 0;
        default: k = $urandom_range(0, 255);
      endcase
      if (r < 3) tick(k);
      else if (r == 3) cyc($urandom_range(0, 799), $urandom_range(0, 524), k);
      else cyc($urandom_range(0, 639), $urandom_range(0, 479), k);
      if (n == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
